pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/pc_src_mux.sv | 13 +
 rtl/pc_fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I widths, fetch FSM encoding and PC helpers
package rv32i_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] PC_INC        = 32'd4;
   localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      FETCH_SETUP = 2'd0,
      FETCH_REQ   = 2'd1,
      FETCH_WAIT  = 2'd2
   } fetch_state_e;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return addr & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/pc_src_mux.sv
// rtl/pc_src_mux.sv - next-PC select between sequential PC and redirect target
module pc_src_mux #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] zero_i,
   input  logic [WIDTH-1:0] one_i,
   input  logic             pc_src_i,
   output logic [WIDTH-1:0] pc_o
);

   assign pc_o = pc_src_i ? one_i : zero_i;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - single-outstanding instruction fetch with redirect/kill
// and a one-entry output buffer toward decode.
module pc_fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        pc_src_i,
   input  logic [31:0] target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        instr_ready_i
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] issued_pc_q, issued_pc_d;
   logic            kill_q, kill_d;
   logic            instr_valid_q, instr_valid_d;
   logic [ILEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] instr_pc_q, instr_pc_d;

   logic            buf_free;
   logic            mem_req;
   logic            req_accept;
   logic            rsp_deliver;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] target_aligned;
   logic [XLEN-1:0] next_pc;

   // A request may only go out when its response is guaranteed a buffer slot.
   assign buf_free    = !instr_valid_q || instr_ready_i;
   assign mem_req     = (state_q == FETCH_REQ) && buf_free;
   assign req_accept  = mem_req && imem_gnt_i;
   assign rsp_deliver = (state_q == FETCH_WAIT) && imem_rvalid_i && !kill_q && !pc_src_i;

   assign seq_pc         = issued_pc_q + PC_INC;
   assign target_aligned = align_pc(target_i);

   pc_src_mux #(
      .WIDTH (XLEN)
   ) u_pc_src_mux (
      .zero_i   (seq_pc),
      .one_i    (target_aligned),
      .pc_src_i (pc_src_i),
      .pc_o     (next_pc)
   );

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      issued_pc_d   = issued_pc_q;
      kill_d        = kill_q;
      instr_valid_d = instr_valid_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;

      if (instr_valid_q && instr_ready_i) begin
         instr_valid_d = 1'b0;
      end

      case (state_q)
         FETCH_SETUP: begin
            state_d = FETCH_REQ;
         end
         FETCH_REQ: begin
            if (req_accept) begin
               state_d     = FETCH_WAIT;
               issued_pc_d = fetch_pc_q;
               kill_d      = pc_src_i;
            end
         end
         FETCH_WAIT: begin
            if (imem_rvalid_i) begin
               state_d = FETCH_REQ;
               kill_d  = 1'b0;
            end else if (pc_src_i) begin
               kill_d = 1'b1;
            end
         end
         default: begin
            state_d = FETCH_SETUP;
         end
      endcase

      if (rsp_deliver) begin
         instr_d       = imem_rdata_i;
         instr_pc_d    = issued_pc_q;
         instr_valid_d = 1'b1;
      end

      // The mux already gives the redirect target priority over issued_pc+4.
      if (rsp_deliver || pc_src_i) begin
         fetch_pc_d = next_pc;
      end

      if (pc_src_i) begin
         instr_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= FETCH_SETUP;
         fetch_pc_q    <= RESET_PC;
         issued_pc_q   <= RESET_PC;
         kill_q        <= 1'b0;
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         issued_pc_q   <= issued_pc_d;
         kill_q        <= kill_d;
         instr_valid_q <= instr_valid_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
      end
   end

   assign imem_req_o    = mem_req;
   assign imem_addr_o   = fetch_pc_q;
   assign instr_valid_o = instr_valid_q;
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;

endmodule
